// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package instr_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_ERR  = 2'd2
    } rd_sel_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Bad fetch/write address: not word aligned or beyond the array's byte span.
    function automatic logic addr_bad(input logic [63:0] addr, input logic [63:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// Plain single-clock word RAM: one byte-enabled write port, one registered read port.
// Read is read-before-write; the read register holds until the next read enable.
module instr_mem_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wbe_i[k]) begin
                    mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Fetch-stage instruction memory: 1-cycle registered read with error flag, byte-enabled
// loader port, and a post-reset clear sweep that gates fetch until the array is filled.
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int unsigned        DATA_W         = 32,
    parameter int unsigned        DEPTH          = 1024,
    parameter int unsigned        ADDR_W         = 32,
    parameter logic [DATA_W-1:0]  INIT_WORD      = DATA_W'(NOP_WORD),
    parameter bit                 CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_instr_o,
    output logic                rd_err_o,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    output logic                wr_err_o,
    output logic                init_done_o
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [63:0] LIMIT     = 64'(DEPTH) * 64'(NB);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam state_e      RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              init_done_q;
    logic              rd_valid_q, rd_err_q, wr_err_q;
    rd_sel_e           sel_q;
    logic [NB-1:0]     byp_be_q;
    logic [DATA_W-1:0] byp_dat_q;

    logic              ready, rd_fire, rd_bad, wr_fire, wr_bad, collide;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic              bank_we;
    logic [IDX_W-1:0]  bank_waddr;
    logic [DATA_W-1:0] bank_wdata, bank_rdata;
    logic [NB-1:0]     bank_wbe;

    assign ready   = (state_q == ST_READY);
    assign rd_bad  = addr_bad(64'(rd_addr_i), LIMIT);
    assign wr_bad  = addr_bad(64'(wr_addr_i), LIMIT);
    assign rd_idx  = rd_addr_i[IDX_W+1:2];
    assign wr_idx  = wr_addr_i[IDX_W+1:2];
    assign rd_fire = ready && rd_req_i;
    assign wr_fire = ready && wr_en_i;
    assign collide = rd_fire && !rd_bad && wr_fire && !wr_bad && (rd_idx == wr_idx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    // The clear sweep owns the write port until READY; the loader is ignored meanwhile.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = wr_idx;
        bank_wdata = wr_data_i;
        bank_wbe   = wr_be_i;
        if (state_q == ST_CLEAR) begin
            bank_we    = 1'b1;
            bank_waddr = idx_q;
            bank_wdata = INIT_WORD;
            bank_wbe   = '1;
        end else begin
            bank_we = wr_fire && !wr_bad;
        end
    end

    instr_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .we_i    (bank_we),
        .waddr_i (bank_waddr),
        .wdata_i (bank_wdata),
        .wbe_i   (bank_wbe),
        .re_i    (rd_fire && !rd_bad),
        .raddr_i (rd_idx),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            sel_q       <= SEL_ZERO;
            byp_be_q    <= '0;
            byp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_q || (state_d == ST_READY);
            rd_valid_q  <= rd_fire;
            rd_err_q    <= rd_fire && rd_bad;
            wr_err_q    <= wr_fire && wr_bad;
            // Select/bypass state only moves on a read so the output word holds between valids.
            if (rd_fire) begin
                sel_q     <= rd_bad ? SEL_ERR : SEL_MEM;
                byp_be_q  <= collide ? wr_be_i : '0;
                byp_dat_q <= wr_data_i;
            end
        end
    end

    // Write-first: bytes written on the read edge override the bank's pre-write word.
    always_comb begin
        rd_instr_o = '0;
        case (sel_q)
            SEL_ERR: rd_instr_o = INIT_WORD;
            SEL_MEM: begin
                for (int k = 0; k < NB; k++) begin
                    rd_instr_o[8*k +: 8] = byp_be_q[k] ? byp_dat_q[8*k +: 8] : bank_rdata[8*k +: 8];
                end
            end
            default: rd_instr_o = '0;
        endcase
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_err_o    = rd_err_q;
    assign wr_err_o    = wr_err_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync (DEPTH=16) against a word-array reference model.
module tb_instr_mem_sync;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic        e;
        logic        we;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic        rd_valid_o;
    logic [31:0] rd_instr_o;
    logic        rd_err_o;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [3:0]  wr_be_i = '0;
    logic        wr_err_o;
    logic        init_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [16];
    logic [31:0] mdl_hold;

    always #5 clk = ~clk;

    instr_mem_sync #(
        .DATA_W         (32),
        .DEPTH          (16),
        .ADDR_W         (32),
        .INIT_WORD      (32'h0),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rd_instr_o  (rd_instr_o),
        .rd_err_o    (rd_err_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_be_i     (wr_be_i),
        .wr_err_o    (wr_err_o),
        .init_done_o (init_done_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd64);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mdl_hold = 32'h0;
    endtask

    task automatic model_step(input logic rq, input logic [31:0] ra, input logic we,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wb,
                              output obs_t ex);
        logic [31:0] w;
        ex.v  = rq;
        ex.e  = rq && is_bad(ra);
        ex.we = we && is_bad(wa);
        if (rq) begin
            if (is_bad(ra)) begin
                mdl_hold = 32'h0;
            end else begin
                w = mdl[ra[5:2]];
                if (we && !is_bad(wa) && wa[5:2] == ra[5:2]) w = merge(w, wd, wb);
                mdl_hold = w;
            end
        end
        if (we && !is_bad(wa)) mdl[wa[5:2]] = merge(mdl[wa[5:2]], wd, wb);
        ex.ins = mdl_hold;
    endtask

    // One clock edge of stimulus; returns what the DUT shows after that edge and what the model expects.
    task automatic cyc(input logic rq, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wb,
                       output obs_t ob, output obs_t ex);
        model_step(rq, ra, we, wa, wd, wb, ex);
        rd_req_i = rq; rd_addr_i = ra;
        wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; wr_be_i = wb;
        @(posedge clk); #1;
        ob = '{v: rd_valid_o, ins: rd_instr_o, e: rd_err_o, we: wr_err_o};
        rd_req_i = 1'b0; wr_en_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        obs_t ob, ex;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b e=%b we=%b done=%b ins=%h, want all 0",
                     rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o);
        end
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (init_done_o) break;
        end
        n_cmp++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL init_done_latency: got %0d cycles, want 16", n);
        end
        model_clear();
        for (int a = 0; a < 64; a += 4) begin
            cyc(1'b1, 32'(a), 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
            n_cmp++;
            if (ob !== obs_t'{v: 1'b1, ins: 32'h0, e: 1'b0, we: 1'b0}) begin
                n_bad++;
                $display("FAIL clear_read[%0h]: got v=%b ins=%h e=%b, want v=1 ins=0 e=0", a, ob.v, ob.ins, ob.e);
            end
        end
    endtask

    task automatic test_byte_enable();
        obs_t ob, ex;
        cyc(1'b0, 32'h0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, ob, ex);
        cyc(1'b0, 32'h0, 1'b1, 32'h8, 32'h0000CAFE, 4'h3, ob, ex);
        n_cmp++;
        if (ob.v !== 1'b0 || ob.we !== 1'b0) begin
            n_bad++;
            $display("FAIL be_write_quiet: got v=%b we=%b, want 0 0", ob.v, ob.we);
        end
        cyc(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob.v !== 1'b1 || ob.ins !== 32'hDEADCAFE || ob.e !== 1'b0) begin
            n_bad++;
            $display("FAIL be_merge: got v=%b ins=%h e=%b, want v=1 ins=deadcafe e=0", ob.v, ob.ins, ob.e);
        end
    endtask

    task automatic test_errors();
        obs_t ob, ex;
        cyc(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob !== obs_t'{v: 1'b1, ins: 32'h0, e: 1'b1, we: 1'b0}) begin
            n_bad++;
            $display("FAIL rd_misaligned: got v=%b ins=%h e=%b, want v=1 ins=0 e=1", ob.v, ob.ins, ob.e);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, ob, ex);
        n_cmp++;
        if (ob.we !== 1'b1 || ob.v !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_range_err: got we=%b v=%b, want we=1 v=0", ob.we, ob.v);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h8, 32'h11111111, 4'h0, ob, ex);
        n_cmp++;
        if (ob.we !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_err_pulse: got we=%b, want 0", ob.we);
        end
        cyc(1'b1, 32'h0, 1'b1, 32'h9, 32'h22222222, 4'hF, ob, ex);
        n_cmp++;
        if (ob !== obs_t'{v: 1'b1, ins: 32'h0, e: 1'b0, we: 1'b1}) begin
            n_bad++;
            $display("FAIL rd0_wr_misaligned: got v=%b ins=%h e=%b we=%b, want 1 0 0 1", ob.v, ob.ins, ob.e, ob.we);
        end
        cyc(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob.ins !== 32'hDEADCAFE || ob.we !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_unchanged: got ins=%h we=%b, want deadcafe 0", ob.ins, ob.we);
        end
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob !== obs_t'{v: 1'b1, ins: 32'h0, e: 1'b1, we: 1'b0}) begin
            n_bad++;
            $display("FAIL rd_range_err: got v=%b ins=%h e=%b, want v=1 ins=0 e=1", ob.v, ob.ins, ob.e);
        end
    endtask

    task automatic test_write_first();
        obs_t ob, ex;
        cyc(1'b1, 32'h4, 1'b1, 32'h4, 32'h12345678, 4'hF, ob, ex);
        n_cmp++;
        if (ob.v !== 1'b1 || ob.ins !== 32'h12345678) begin
            n_bad++;
            $display("FAIL write_first: got v=%b ins=%h, want 1 12345678", ob.v, ob.ins);
        end
        cyc(1'b1, 32'h4, 1'b1, 32'hC, 32'hAAAA5555, 4'hF, ob, ex);
        n_cmp++;
        if (ob.ins !== 32'h12345678) begin
            n_bad++;
            $display("FAIL diff_word: got ins=%h, want 12345678", ob.ins);
        end
        cyc(1'b1, 32'h4, 1'b1, 32'h4, 32'hFFFF0000, 4'hC, ob, ex);
        n_cmp++;
        if (ob.ins !== 32'hFFFF5678) begin
            n_bad++;
            $display("FAIL write_first_partial: got ins=%h, want ffff5678", ob.ins);
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob, ex;
        logic [31:0] want [3];
        want[0] = 32'h0; want[1] = 32'hFFFF5678; want[2] = 32'hDEADCAFE;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'(4 * i), 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
            n_cmp++;
            if (ob.v !== 1'b1 || ob.ins !== want[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got v=%b ins=%h, want 1 %h", i, ob.v, ob.ins, want[i]);
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob.v !== 1'b0 || ob.ins !== 32'hDEADCAFE || ob.e !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: got v=%b ins=%h e=%b, want 0 deadcafe 0", ob.v, ob.ins, ob.e);
        end
    endtask

    task automatic test_random();
        obs_t ob, ex;
        logic rq, we;
        logic [31:0] ra, wa, wd;
        logic [3:0] wb;
        for (int i = 0; i < 400; i++) begin
            rq = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 80)) : 32'($urandom_range(0, 17) * 4);
            wa = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 80)) : 32'($urandom_range(0, 17) * 4);
            wd = $urandom;
            wb = 4'($urandom_range(0, 15));
            cyc(rq, ra, we, wa, wd, wb, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL rand[%0d]: got v=%b ins=%h e=%b we=%b, want v=%b ins=%h e=%b we=%b",
                         i, ob.v, ob.ins, ob.e, ob.we, ex.v, ex.ins, ex.e, ex.we);
            end
        end
        n_cmp++;
        if (init_done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL init_done_sticky: got %b, want 1", init_done_o);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        obs_t ob, ex;
        rd_req_i = 1'b1; rd_addr_i = 32'h8;
        @(posedge clk); #1;
        rd_req_i = 1'b0;
        n_cmp++;
        if (rd_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_valid: got %b, want 1", rd_valid_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_ready_async: got v=%b e=%b we=%b done=%b ins=%h, want all 0",
                     rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o);
        end
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_clear_async: got v=%b e=%b we=%b done=%b ins=%h, want all 0",
                     rd_valid_o, rd_err_o, wr_err_o, init_done_o, rd_instr_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (init_done_o) break;
        end
        n_cmp++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL restart_latency: got %0d cycles, want 16", n);
        end
        model_clear();
        cyc(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0, ob, ex);
        n_cmp++;
        if (ob !== obs_t'{v: 1'b1, ins: 32'h0, e: 1'b0, we: 1'b0}) begin
            n_bad++;
            $display("FAIL recleared_read: got v=%b ins=%h e=%b, want v=1 ins=0 e=0", ob.v, ob.ins, ob.e);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_errors();
        test_write_first();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
